uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receive byte engine; feeds the clock-time frame parser (minute/ore/load) with one byte per received frame.
- Synchronises `i_Rx_Serial`, detects the start bit, samples mid-bit, checks the stop bit.
- Output is a validated byte plus a one-cycle strobe. No FIFO: the consumer must take each byte on the strobe cycle.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit (e.g. 10 MHz / 115200). Legal range >= 4.

Ports:
- i_Clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- i_Rx_Serial  input  1  asynchronous serial line; idle high.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received valid byte.
- o_Rx_Byte  output  8  last valid received byte, LSB received first.
- o_Rx_Err  output  1  one-cycle pulse: framing error (stop bit sampled 0).
- o_Rx_Busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; o_Rx_DV=0, o_Rx_Err=0, o_Rx_Busy=0, o_Rx_Byte=8'h00.
  - Bit counter and clock counter = 0.
  - Synchroniser flops = 1 (idle line).
- Synchroniser: 2 flops; rx_s is the second flop. Input-to-rx_s latency is 2 cycles.
- Define H = (CLKS_PER_BIT-1)/2, using integer division.
- State machine (IDLE, START, DATA, STOP, CLEANUP, BREAK):
  - IDLE: clk_cnt=0, bit_idx=0. If rx_s==0, go to START.
  - START: clk_cnt increments. When clk_cnt==H, sample rx_s:
    - rx_s==0: clk_cnt=0, go to DATA.
    - rx_s==1: treat as a glitch and return to IDLE with no output.
  - DATA: clk_cnt increments. When clk_cnt==CLKS_PER_BIT-1, clk_cnt=0 and shift[bit_idx]=rx_s.
    - bit_idx 0..7; after bit_idx==7 is sampled, go to STOP.
  - STOP: when clk_cnt==CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1: o_Rx_Byte<=shift, o_Rx_DV<=1, go to CLEANUP.
    - rx_s==0: o_Rx_Err<=1, o_Rx_Byte unchanged, go to BREAK.
  - CLEANUP: exactly one cycle. o_Rx_DV returns to 0. Go to IDLE.
  - BREAK: o_Rx_Err returns to 0 after one cycle. Remain in BREAK until rx_s==1, then go to IDLE. This prevents a held-low line (break) from producing 0x00 frames.
- Latency: let S0 be the first cycle IDLE sees rx_s==0.
  - Stop bit is sampled at S0+1+H+9*CLKS_PER_BIT (±0 cycles; the bench models this exactly).
  - o_Rx_DV / o_Rx_Err are high in the cycle after the sample.
- Back-to-back frames: a start bit arriving right after the stop bit is accepted. CLEANUP→IDLE costs 2 cycles, which fits within the remaining half stop bit.
- Simultaneous events: o_Rx_DV and o_Rx_Err are mutually exclusive and never both high.
- o_Rx_Byte changes only on a valid frame. It is stable between strobes.
- Reset asserted mid-frame: everything returns to reset values immediately; the partial frame is discarded.
  - After reset is released, a line that is still low is not a start bit: rx_s must be seen high before the first start. IDLE is entered via the BREAK rule when rx_s==0 at reset release.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_idx is 3 bits. Neither counter ever wraps.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4, BREAK=5, 3 bits.
  - Default CLKS_PER_BIT constant.
  - DATA_BITS=8.
- One sub-module is natural: sync_2ff (width-1, reset value 1, async active-low reset). It is reused for any other asynchronous inputs in the design.
- Everything else is inline.

Test Plan:
- Reset: hold reset=0 for 5 cycles with the line high -> o_Rx_DV=0, o_Rx_Err=0, o_Rx_Busy=0, o_Rx_Byte=8'h00.
- Single frame 8'hA5 at CLKS_PER_BIT=87, LSB first, stop=1 -> exactly one o_Rx_DV pulse at the latency above; o_Rx_Byte=8'hA5; o_Rx_Err never high.
- Start-bit glitch: line low for 20 cycles (< H=43), then high -> no DV, no Err; o_Rx_Busy returns to 0; o_Rx_Byte unchanged.
- Framing error: send 8'hA5 (valid), then 8'h3C with stop=0 and the line held low for 500 cycles -> one o_Rx_Err pulse; o_Rx_Byte stays 8'hA5; no DV while the line is low; the next valid 8'h81 is received correctly once the line returns high.
- Back-to-back: 8'h00 then 8'hFF with no idle gap -> two DV pulses exactly 10*87 cycles apart; bytes 8'h00 then 8'hFF.
- Reset mid-frame: assert reset=0 during bit 4 of 8'h5A -> outputs return to reset values; no DV; after release and line idle, 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 UART receive path: state encoding, frame size
// and the default bit period.
package uart_pkg;

   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned CLKS_PER_BIT_DEF = 87;
   localparam int unsigned ST_W             = 3;

   typedef logic [ST_W-1:0] state_t;

   localparam state_t IDLE    = 3'd0;
   localparam state_t START   = 3'd1;
   localparam state_t DATA    = 3'd2;
   localparam state_t STOP    = 3'd3;
   localparam state_t CLEANUP = 3'd4;
   localparam state_t BREAK   = 3'd5;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to a programmable
// value so an idle-high line reads as idle straight out of reset.
module sync_2ff #(
   parameter int unsigned         WIDTH   = 1,
   parameter logic [WIDTH-1:0]    RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, finds the start bit, samples each
// bit at its centre and emits one validated byte (or a framing-error pulse).
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 i_Clock,
   input  logic                 reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Rx_Err,
   output logic                 o_Rx_Busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned LAST  = CLKS_PER_BIT - 1;

   localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(LAST);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   state_t               state, state_nxt;
   logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic [1:0]           warm;
   logic                 armed;
   logic                 line_valid;
   logic                 dv_nxt, err_nxt, busy_nxt;
   logic [DATA_BITS-1:0] byte_nxt;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (i_Clock),
      .rst_n (reset),
      .d     (i_Rx_Serial),
      .q     (rx_s)
   );

   // The synchroniser reports its reset value for two cycles; only after that
   // does rx_s reflect the real line, and a start needs a prior high level.
   assign line_valid = (warm == 2'd2);

   always_ff @(posedge i_Clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         warm      <= 2'd0;
         armed     <= 1'b0;
         o_Rx_DV   <= 1'b0;
         o_Rx_Err  <= 1'b0;
         o_Rx_Busy <= 1'b0;
         o_Rx_Byte <= '0;
      end else begin
         state     <= state_nxt;
         clk_cnt   <= clk_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift     <= shift_nxt;
         warm      <= line_valid ? warm : warm + 2'd1;
         armed     <= armed | (line_valid & rx_s);
         o_Rx_DV   <= dv_nxt;
         o_Rx_Err  <= err_nxt;
         o_Rx_Busy <= busy_nxt;
         o_Rx_Byte <= byte_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      case (state)
         IDLE: begin
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
            // A line already low when we come out of reset is a break, not a start.
            if (line_valid && !rx_s) begin
               state_nxt = armed ? START : BREAK;
            end
         end
         START: begin
            if (clk_cnt == HALF_C) begin
               clk_cnt_nxt = '0;
               state_nxt   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (clk_cnt == LAST_C) begin
               clk_cnt_nxt        = '0;
               shift_nxt[bit_idx] = rx_s;
               if (bit_idx == LAST_IDX) begin
                  bit_idx_nxt = '0;
                  state_nxt   = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end else begin
               clk_cnt_nxt = clk_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (clk_cnt == LAST_C) begin
               clk_cnt_nxt = '0;
               state_nxt   = rx_s ? CLEANUP : BREAK;
            end else begin
               clk_cnt_nxt = clk_cnt + CNT_W'(1);
            end
         end
         CLEANUP: begin
            state_nxt = IDLE;
         end
         BREAK: begin
            clk_cnt_nxt = '0;
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt   = IDLE;
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
         end
      endcase
   end

   // Strobes and the byte register only move on the stop-bit sample.
   always_comb begin
      dv_nxt   = 1'b0;
      err_nxt  = 1'b0;
      byte_nxt = o_Rx_Byte;
      busy_nxt = (state_nxt != IDLE);
      if (state == STOP && clk_cnt == LAST_C) begin
         if (rx_s) begin
            dv_nxt   = 1'b1;
            byte_nxt = shift;
         end else begin
            err_nxt  = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written reset
// and glitch sequences, and random frames against a frame-level model.
module tb_uart_rx;

   localparam int C = 87;
   localparam int H = (C - 1) / 2;

   typedef struct {
      logic [7:0] data;
      bit         stop;
      int         hold;
      int         gap;
      bit         exp_dv;
      bit         exp_err;
      logic [7:0] exp_byte;
   } vec_t;

   typedef struct {
      int         cyc;
      bit         is_err;
      logic [7:0] b;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       line;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
   logic       o_Rx_Err;
   logic       o_Rx_Busy;

   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         overlap = 0;
   int         unstable = 0;
   logic [7:0] prev_byte = 8'h00;
   logic       prev_rst = 1'b0;
   ev_t        ev_q[$];
   logic [7:0] last_good;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .i_Clock     (clk),
      .reset       (rst_n),
      .i_Rx_Serial (line),
      .o_Rx_DV     (o_Rx_DV),
      .o_Rx_Byte   (o_Rx_Byte),
      .o_Rx_Err    (o_Rx_Err),
      .o_Rx_Busy   (o_Rx_Busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor: records every strobe with its cycle and watches the byte register.
   always @(negedge clk) begin
      if (o_Rx_DV)  ev_q.push_back('{cyc, 1'b0, o_Rx_Byte});
      if (o_Rx_Err) ev_q.push_back('{cyc, 1'b1, o_Rx_Byte});
      if (o_Rx_DV && o_Rx_Err) overlap <= overlap + 1;
      if (rst_n && prev_rst && !o_Rx_DV && o_Rx_Byte != prev_byte) unstable <= unstable + 1;
      prev_byte <= o_Rx_Byte;
      prev_rst  <= rst_n;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame starting now (just after a rising edge); returns the start cycle.
   task automatic send_frame(input logic [7:0] d, input bit stop, input int hold, output int k);
      line = 1'b0;
      k    = cyc;
      for (int i = 0; i < 8; i++) begin
         wait_cyc(C);
         line = d[i];
      end
      wait_cyc(C);
      line = stop;
      wait_cyc(C + (stop ? 0 : hold));
      line = 1'b1;
   endtask

   // Model: line falls in cycle k, rx_s follows 2 cycles later (S0), strobe at S0+2+H+9C.
   task automatic run_frame(input logic [7:0] d, input bit stop, input int hold, input int gap,
                            input bit exp_dv, input bit exp_err, input logic [7:0] exp_byte,
                            output int dv_cyc);
      int k;
      send_frame(d, stop, hold, k);
      dv_cyc = -1;
      chk("event_count", ev_q.size(), (exp_dv || exp_err) ? 1 : 0);
      if (ev_q.size() > 0) begin
         chk("event_cycle", ev_q[0].cyc, k + 4 + H + 9 * C);
         chk("event_is_err", int'(ev_q[0].is_err), int'(exp_err));
         if (!ev_q[0].is_err) begin
            chk("dv_byte", int'(ev_q[0].b), int'(exp_byte));
            dv_cyc = ev_q[0].cyc;
         end
      end
      chk("byte_after", int'(o_Rx_Byte), int'(exp_byte));
      ev_q.delete();
      wait_cyc(gap);
   endtask

   initial begin
      vec_t tbl[7];
      int   dv_cyc;
      int   prev_dv_cyc;
      int   k;

      tbl[0] = '{8'hA5, 1'b1, 0,   10, 1'b1, 1'b0, 8'hA5};
      tbl[1] = '{8'h3C, 1'b0, 500, 10, 1'b0, 1'b1, 8'hA5};
      tbl[2] = '{8'h81, 1'b1, 0,   0,  1'b1, 1'b0, 8'h81};
      tbl[3] = '{8'h00, 1'b1, 0,   0,  1'b1, 1'b0, 8'h00};
      tbl[4] = '{8'hFF, 1'b1, 0,   20, 1'b1, 1'b0, 8'hFF};
      tbl[5] = '{8'h55, 1'b0, 0,   10, 1'b0, 1'b1, 8'hFF};
      tbl[6] = '{8'h0F, 1'b1, 0,   5,  1'b1, 1'b0, 8'h0F};

      // Reset with idle line.
      rst_n = 1'b0;
      line  = 1'b1;
      wait_cyc(5);
      chk("reset_dv", int'(o_Rx_DV), 0);
      chk("reset_err", int'(o_Rx_Err), 0);
      chk("reset_busy", int'(o_Rx_Busy), 0);
      chk("reset_byte", int'(o_Rx_Byte), 0);
      rst_n = 1'b1;
      wait_cyc(10);

      // Directed frame table.
      prev_dv_cyc = -1;
      for (int i = 0; i < 7; i++) begin
         run_frame(tbl[i].data, tbl[i].stop, tbl[i].hold, tbl[i].gap,
                   tbl[i].exp_dv, tbl[i].exp_err, tbl[i].exp_byte, dv_cyc);
         if (i > 0 && tbl[i-1].gap == 0 && tbl[i-1].exp_dv && tbl[i].exp_dv)
            chk("b2b_spacing", dv_cyc - prev_dv_cyc, 10 * C);
         prev_dv_cyc = dv_cyc;
      end
      last_good = 8'h0F;

      // Start-bit glitch shorter than half a bit.
      line = 1'b0;
      wait_cyc(20);
      line = 1'b1;
      wait_cyc(60);
      chk("glitch_events", ev_q.size(), 0);
      chk("glitch_busy", int'(o_Rx_Busy), 0);
      chk("glitch_byte", int'(o_Rx_Byte), int'(last_good));
      ev_q.delete();

      // Reset asserted during bit 4 of 0x5A.
      send_frame_partial: begin
         logic [7:0] d;
         d    = 8'h5A;
         line = 1'b0;
         for (int i = 0; i < 5; i++) begin
            wait_cyc(C);
            line = d[i];
         end
         wait_cyc(C / 2);
         chk("midframe_busy_before", int'(o_Rx_Busy), 1);
         rst_n = 1'b0;
         #1;
         chk("midframe_dv", int'(o_Rx_DV), 0);
         chk("midframe_err", int'(o_Rx_Err), 0);
         chk("midframe_busy", int'(o_Rx_Busy), 0);
         chk("midframe_byte", int'(o_Rx_Byte), 0);
      end
      wait_cyc(5);
      line  = 1'b1;
      rst_n = 1'b1;
      wait_cyc(20);
      chk("midframe_events", ev_q.size(), 0);
      ev_q.delete();
      run_frame(8'hC3, 1'b1, 0, 10, 1'b1, 1'b0, 8'hC3, dv_cyc);

      // Reset released while the line is held low: must not be taken as a start.
      rst_n = 1'b0;
      line  = 1'b0;
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(2 * 10 * C);
      line = 1'b1;
      wait_cyc(10);
      chk("lowrel_events", ev_q.size(), 0);
      chk("lowrel_byte", int'(o_Rx_Byte), 0);
      chk("lowrel_busy", int'(o_Rx_Busy), 0);
      ev_q.delete();
      run_frame(8'h96, 1'b1, 0, 10, 1'b1, 1'b0, 8'h96, dv_cyc);
      last_good = 8'h96;

      // Random frames against the frame-level model.
      for (int i = 0; i < 24; i++) begin
         logic [7:0] d;
         bit         stop;
         int         hold;
         int         gap;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         hold = stop ? 0 : int'($urandom_range(0, 150));
         gap  = stop ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 40));
         if (stop) last_good = d;
         run_frame(d, stop, hold, gap, stop, !stop, last_good, dv_cyc);
      end

      wait_cyc(5);
      chk("dv_err_overlap", overlap, 0);
      chk("byte_unstable", unstable, 0);
      k = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
